decoder_scan: RTL

// - Parametrised, registered binary-to-one-hot decoder, SEL_W bits in, 2**SEL_W lines out.
// - Two modes. DIRECT decodes the sel input. SCAN auto-cycles the active line with a

---
 rtl/decoder_pkg.sv | 19 +
 rtl/onehot_dec.sv | 19 +
 rtl/decoder_scan.sv | 116 +++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder with scan mode.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_e;

   // Width-independent one-hot: bit 'pos' of onehot(idx) for any output width.
   function automatic logic onehot(input int unsigned idx, input int unsigned pos);
      return (idx == pos) ? 1'b1 : 1'b0;
   endfunction

   function automatic logic apply_pol(input logic b, input logic active_low);
      return b ^ active_low;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder, SEL_W bits in, 2**SEL_W lines out.
module onehot_dec
   import decoder_pkg::*;
#(
   parameter  int SEL_W = 2,
   localparam int OUT_W = 2**SEL_W
) (
   input  logic [SEL_W-1:0] sel_i,
   output logic [OUT_W-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < OUT_W; i++) begin
         onehot_o[i] = onehot(32'(sel_i), 32'(i));
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder: DIRECT decodes sel, SCAN auto-cycles the active line
// with a programmable dwell. Every output is a flop.
module decoder_scan
   import decoder_pkg::*;
#(
   parameter  int SEL_W      = 2,
   parameter  int DWELL      = 4,
   parameter  bit ACTIVE_LOW = 1'b0,
   localparam int OUT_W      = 2**SEL_W,
   localparam int CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   input  logic             load,
   output logic [OUT_W-1:0] out,
   output logic [SEL_W-1:0] idx,
   output logic             valid,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST   = '1;
   localparam logic [OUT_W-1:0] OUT_IDLE   = ACTIVE_LOW ? '1 : '0;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic [OUT_W-1:0] dec_s;

   // The decoder looks at the next index so out lines up with idx in the same cycle.
   onehot_dec #(.SEL_W(SEL_W)) u_dec (
      .sel_i    (idx_d),
      .onehot_o (dec_s)
   );

   always_comb begin
      state_d = IDLE;
      idx_d   = idx_q;
      dwell_d = dwell_q;
      wrap_d  = 1'b0;
      out_d   = OUT_IDLE;

      if (!en) begin
         state_d = IDLE;
      end else if (mode) begin
         state_d = SCAN;
      end else begin
         state_d = DIRECT;
      end

      case (state_d)
         IDLE: begin
            idx_d   = idx_q;
            dwell_d = dwell_q;
         end
         DIRECT: begin
            idx_d   = sel;
            dwell_d = '0;
         end
         SCAN: begin
            // Entry discards any partial dwell; load wins over a coincident expiry.
            if (state_q != SCAN) begin
               dwell_d = '0;
            end else if (load) begin
               idx_d   = sel;
               dwell_d = '0;
            end else if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               idx_d   = idx_q + 1'b1;
               wrap_d  = (idx_q == IDX_LAST) ? 1'b1 : 1'b0;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         default: begin
            idx_d   = idx_q;
            dwell_d = '0;
         end
      endcase

      valid_d = (state_d != IDLE) ? 1'b1 : 1'b0;
      for (int i = 0; i < OUT_W; i++) begin
         out_d[i] = apply_pol(dec_s[i] & valid_d, ACTIVE_LOW);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         dwell_q <= '0;
         out_q   <= OUT_IDLE;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dwell_q <= dwell_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign out   = out_q;
   assign idx   = idx_q;
   assign valid = valid_q;
   assign wrap  = wrap_q;

endmodule
